// File: rtl/cbi980_pkg.sv
// Shared definitions for the CBI980 I2S transmit path: sequencer states,
// default geometry and frame-length helper.
package cbi980_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  localparam int DEF_SAMPLE_W   = 16;
  localparam int DEF_SLOT_W     = 32;
  localparam int DEF_DIV_W      = 8;
  localparam int DEF_FRAME_BITS = 2 * DEF_SLOT_W;

  // BCLK periods in one stereo frame (two channel slots).
  function automatic int frame_bits(input int slot_w);
    return 2 * slot_w;
  endfunction

endpackage

// File: rtl/cbi980_bclk_gen.sv
// BCLK generator: programmable half-period divider, bit clock register and
// a fall-tick strobe asserted in the cycle that drives BCLK from 1 to 0.
module cbi980_bclk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div_max,
  output logic             bclk,
  output logic             fall_tick
);

  logic [DIV_W-1:0] cnt;
  logic             term;

  assign term      = en && (cnt == div_max);
  assign fall_tick = term && bclk;

  // Half-period counter; toggles BCLK at terminal count, clear restarts low.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt  <= '0;
      bclk <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      bclk <= 1'b0;
    end else if (term) begin
      cnt  <= '0;
      bclk <= ~bclk;
    end else if (en) begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cbi980_i2s_tx.sv
// CBI980 I2S transmit sequencer: one-entry sample-pair holding buffer,
// start/run/stop control and MSB-first I2S serialisation with the MSB one
// BCLK after the LRCK edge.
module cbi980_i2s_tx
  import cbi980_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int SLOT_W   = DEF_SLOT_W,
  parameter int DIV_W    = DEF_DIV_W
) (
  input  logic                       aclk,
  input  logic                       arst,
  input  logic                       enable,
  input  logic [DIV_W-1:0]           clkdiv,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic signed [SAMPLE_W-1:0] s_left,
  input  logic signed [SAMPLE_W-1:0] s_right,
  output logic                       busy,
  output logic                       underrun,
  output logic                       i2s_bclk,
  output logic                       i2s_lrck,
  output logic                       i2s_sdata
);

  localparam int FRAME_BITS = frame_bits(SLOT_W);
  localparam int F_W        = $clog2(FRAME_BITS);
  localparam int IDX_W      = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;

  state_t                      state;
  logic [DIV_W-1:0]            div_q;
  logic [F_W-1:0]              f_q;
  logic                        full_q;
  logic signed [SAMPLE_W-1:0]  buf_l;
  logic signed [SAMPLE_W-1:0]  buf_r;
  logic signed [SAMPLE_W-1:0]  sh_l;
  logic signed [SAMPLE_W-1:0]  sh_r;

  logic                        fall_tick;
  logic                        start;
  logic                        wrap;
  logic                        stop_done;
  logic                        load;
  logic                        adv;
  logic                        wr;
  logic [F_W-1:0]              f_nxt;
  logic [F_W-1:0]              p_nxt;
  logic [IDX_W-1:0]            idx;
  logic                        lr_nxt;
  logic                        bit_nxt;

  assign s_ready   = ~full_q;
  assign wr        = s_valid && !full_q;
  assign start     = (state == ST_IDLE) && enable;
  assign wrap      = fall_tick && (f_q == F_W'(FRAME_BITS - 1));
  assign stop_done = (state == ST_STOP) && !enable && wrap;
  // A wrap reloads unless the sequencer is finishing a stop.
  assign load      = start || (wrap && !stop_done);
  assign adv       = start || fall_tick;

  cbi980_bclk_gen #(
    .DIV_W (DIV_W)
  ) u_bclk_gen (
    .clk       (aclk),
    .arst      (arst),
    .clr       (start || stop_done),
    .en        (busy),
    .div_max   (div_q),
    .bclk      (i2s_bclk),
    .fall_tick (fall_tick)
  );

  // Next frame position and the serial bit/word select it implies.
  always_comb begin
    f_nxt   = '0;
    lr_nxt  = 1'b0;
    p_nxt   = '0;
    idx     = '0;
    bit_nxt = 1'b0;
    if (!start && !wrap) f_nxt = f_q + 1'b1;
    lr_nxt = (f_nxt >= F_W'(SLOT_W));
    p_nxt  = lr_nxt ? (f_nxt - F_W'(SLOT_W)) : f_nxt;
    if ((p_nxt != '0) && (p_nxt <= F_W'(SAMPLE_W))) begin
      idx     = IDX_W'(SAMPLE_W - int'(p_nxt));
      bit_nxt = lr_nxt ? sh_r[idx] : sh_l[idx];
    end
  end

  // Sequencer FSM, frame counter, buffer flag and registered I2S outputs.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      div_q     <= '0;
      f_q       <= '0;
      full_q    <= 1'b0;
      underrun  <= 1'b0;
      i2s_lrck  <= 1'b0;
      i2s_sdata <= 1'b0;
    end else begin
      underrun <= 1'b0;
      case (state)
        ST_IDLE: if (enable) begin
          state <= ST_RUN;
          busy  <= 1'b1;
        end
        ST_RUN: if (!enable) state <= ST_STOP;
        ST_STOP: begin
          if (enable) begin
            state <= ST_RUN;
          end else if (wrap) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (start) div_q <= clkdiv;
      if (adv) begin
        f_q       <= f_nxt;
        i2s_lrck  <= lr_nxt;
        i2s_sdata <= bit_nxt;
      end
      if (load && !full_q) underrun <= 1'b1;
      if (load && full_q) begin
        full_q <= 1'b0;
      end else if (wr) begin
        full_q <= 1'b1;
      end
    end
  end

  // Sample storage: buffer capture on handshake, shift registers on frame load.
  always_ff @(posedge aclk) begin
    if (wr) begin
      buf_l <= s_left;
      buf_r <= s_right;
    end
    if (load) begin
      sh_l <= full_q ? buf_l : '0;
      sh_r <= full_q ? buf_r : '0;
    end
  end

endmodule
